// File: rtl/aes_round_ctrl.sv
// Sequencing controller for the iterative AES-128 encrypt datapath: load, step rounds,
// select the final-round path, then hold the result under a valid/ack handshake.
module aes_round_ctrl #(
  parameter int unsigned NUM_ROUNDS       = 10,
  parameter int unsigned ROUND_W          = 8,
  parameter int unsigned CYCLES_PER_ROUND = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               ready,
  output logic               busy,
  output logic               load_en,
  output logic               reg_en,
  output logic               last_round,
  output logic [ROUND_W-1:0] round,
  output logic               out_valid,
  input  logic               out_ack
);

  localparam int unsigned SUB_W = (CYCLES_PER_ROUND > 1) ? $clog2(CYCLES_PER_ROUND) : 1;
  localparam logic [SUB_W-1:0]   SUB_LAST      = SUB_W'(CYCLES_PER_ROUND - 1);
  localparam logic [ROUND_W-1:0] LAST_ROUND    = ROUND_W'(NUM_ROUNDS);
  localparam logic               FIRST_IS_LAST = (NUM_ROUNDS == 1);
  localparam logic               SINGLE_CYCLE  = (CYCLES_PER_ROUND == 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [SUB_W-1:0] subCnt;

  // round doubles as the round counter; every output is a flop updated alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      subCnt     <= '0;
      round      <= '0;
      ready      <= 1'b1;
      busy       <= 1'b0;
      load_en    <= 1'b0;
      reg_en     <= 1'b0;
      last_round <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            ready   <= 1'b0;
            busy    <= 1'b1;
            load_en <= 1'b1;
          end
        end
        LOAD: begin
          state      <= ROUND;
          load_en    <= 1'b0;
          round      <= ROUND_W'(1);
          subCnt     <= '0;
          last_round <= FIRST_IS_LAST;
          reg_en     <= SINGLE_CYCLE;
        end
        ROUND: begin
          if (subCnt == SUB_LAST) begin
            subCnt <= '0;
            if (round < LAST_ROUND) begin
              round      <= round + ROUND_W'(1);
              last_round <= ((round + ROUND_W'(1)) == LAST_ROUND);
              reg_en     <= SINGLE_CYCLE;
            end else begin
              state      <= DONE;
              round      <= '0;
              last_round <= 1'b0;
              reg_en     <= 1'b0;
              out_valid  <= 1'b1;
            end
          end else begin
            subCnt <= subCnt + SUB_W'(1);
            reg_en <= ((subCnt + SUB_W'(1)) == SUB_LAST);
          end
        end
        DONE: begin
          if (out_ack) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: three parameterisations share one stimulus stream and are
// checked every cycle against an elapsed-cycle timeline model, plus a directed vector table.
module tb_aes_round_ctrl;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       loadEn;
    logic       regEn;
    logic       lastRound;
    logic [7:0] round;
    logic       outValid;
  } obs_t;

  typedef struct {
    logic rst;
    logic st;
    logic ack;
    obs_t exp;
  } vec_t;

  localparam int NR [3] = '{10, 10, 1};
  localparam int CR [3] = '{1, 3, 1};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic outAck = 1'b1;

  logic       rdy [3];
  logic       bsy [3];
  logic       ldEn [3];
  logic       rgEn [3];
  logic       lstRnd [3];
  logic [7:0] rnd [3];
  logic       vld [3];

  int  nChecks = 0;
  int  nFail = 0;
  bit  monEn = 1'b0;
  bit  act [3] = '{1'b0, 1'b0, 1'b0};
  int  kCyc [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  aes_round_ctrl #(.NUM_ROUNDS(10), .ROUND_W(8), .CYCLES_PER_ROUND(1)) dut0 (
    .clk(clk), .reset(reset), .start(start), .ready(rdy[0]), .busy(bsy[0]),
    .load_en(ldEn[0]), .reg_en(rgEn[0]), .last_round(lstRnd[0]), .round(rnd[0]),
    .out_valid(vld[0]), .out_ack(outAck));

  aes_round_ctrl #(.NUM_ROUNDS(10), .ROUND_W(8), .CYCLES_PER_ROUND(3)) dut1 (
    .clk(clk), .reset(reset), .start(start), .ready(rdy[1]), .busy(bsy[1]),
    .load_en(ldEn[1]), .reg_en(rgEn[1]), .last_round(lstRnd[1]), .round(rnd[1]),
    .out_valid(vld[1]), .out_ack(outAck));

  aes_round_ctrl #(.NUM_ROUNDS(1), .ROUND_W(8), .CYCLES_PER_ROUND(1)) dut2 (
    .clk(clk), .reset(reset), .start(start), .ready(rdy[2]), .busy(bsy[2]),
    .load_en(ldEn[2]), .reg_en(rgEn[2]), .last_round(lstRnd[2]), .round(rnd[2]),
    .out_valid(vld[2]), .out_ack(outAck));

  function automatic obs_t mkObs(logic r, logic b, logic l, logic g, logic s,
                                 logic [7:0] n, logic v);
    obs_t o;
    o.ready = r; o.busy = b; o.loadEn = l; o.regEn = g;
    o.lastRound = s; o.round = n; o.outValid = v;
    return o;
  endfunction

  function automatic obs_t getObs(int d);
    return mkObs(rdy[d], bsy[d], ldEn[d], rgEn[d], lstRnd[d], rnd[d], vld[d]);
  endfunction

  // Expected outputs k cycles after the accepting edge: 1 = load, then n rounds of c cycles, then done
  function automatic obs_t expOut(int n, int c, bit a, int k);
    int r;
    if (!a) return mkObs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    if (k == 1) return mkObs(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    if (k <= 1 + n * c) begin
      r = (k - 2) / c + 1;
      return mkObs(1'b0, 1'b1, 1'b0, ((k - 2) % c) == (c - 1), r == n, 8'(r), 1'b0);
    end
    return mkObs(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
  endfunction

  task automatic chk(input string name, input obs_t got, input obs_t exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s at %0t: got rdy=%b bsy=%b ld=%b rg=%b last=%b rnd=%0d vld=%b, want rdy=%b bsy=%b ld=%b rg=%b last=%b rnd=%0d vld=%b",
               name, $time, got.ready, got.busy, got.loadEn, got.regEn, got.lastRound, got.round,
               got.outValid, exp.ready, exp.busy, exp.loadEn, exp.regEn, exp.lastRound, exp.round,
               exp.outValid);
    end
  endtask

  task automatic chkInt(input string name, input int got, input int exp);
    nChecks++;
    if (got != exp) begin
      nFail++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, got, exp);
    end
  endtask

  // Reference timeline advances on each rising edge from the sampled inputs
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        act[d] = 1'b0;
        kCyc[d] = 0;
      end else if (!act[d]) begin
        if (start) begin
          act[d] = 1'b1;
          kCyc[d] = 1;
        end
      end else if (kCyc[d] >= 2 + NR[d] * CR[d]) begin
        if (outAck) act[d] = 1'b0;
      end else begin
        kCyc[d] = kCyc[d] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (monEn) begin
      for (int d = 0; d < 3; d++)
        chk($sformatf("model_dut%0d", d), getObs(d), expOut(NR[d], CR[d], act[d], kCyc[d]));
    end
  end

  vec_t vt [16];

  initial begin
    int lat;
    int regCnt0, ldCnt0, regCnt2, ldCnt2;

    // Directed vectors for the default configuration (inputs applied before edge i, outputs after it)
    vt[0] = '{1'b1, 1'b0, 1'b1, mkObs(1, 0, 0, 0, 0, 8'd0, 0)};
    vt[1] = '{1'b0, 1'b1, 1'b1, mkObs(0, 1, 1, 0, 0, 8'd0, 0)};
    for (int i = 2; i <= 11; i++)
      vt[i] = '{1'b0, 1'b0, 1'b1, mkObs(0, 1, 0, 1, i == 11, 8'(i - 1), 0)};
    vt[12] = '{1'b0, 1'b0, 1'b1, mkObs(0, 1, 0, 0, 0, 8'd0, 1)};
    vt[13] = '{1'b0, 1'b0, 1'b1, mkObs(1, 0, 0, 0, 0, 8'd0, 0)};
    vt[14] = '{1'b1, 1'b1, 1'b1, mkObs(1, 0, 0, 0, 0, 8'd0, 0)};
    vt[15] = '{1'b0, 1'b0, 1'b1, mkObs(1, 0, 0, 0, 0, 8'd0, 0)};

    repeat (2) @(posedge clk);
    @(negedge clk);
    monEn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      reset = vt[i].rst; start = vt[i].st; outAck = vt[i].ack;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), getObs(0), vt[i].exp);
    end

    // Acceptance-to-valid latency with three cycles per round
    @(negedge clk);
    reset = 1'b0; start = 1'b1; outAck = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (vld[1] !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chkInt("latency_c3", lat, 32);
    repeat (3) @(negedge clk);

    // Hold DONE with ack low; a start during the hold must be ignored
    outAck = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (vld[0] !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chkInt("latency_default", lat, 12);
    for (int i = 0; i < 20; i++) begin
      start = (i == 10);
      @(negedge clk);
    end
    start = 1'b0;
    lat = 0;
    while (vld[1] !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("hold_dut0", getObs(0), mkObs(0, 1, 0, 0, 0, 8'd0, 1));
    outAck = 1'b1;
    @(negedge clk);
    chk("ack_release", getObs(0), mkObs(1, 0, 0, 0, 0, 8'd0, 0));
    repeat (2) @(negedge clk);

    // Reset while the default instance is in round 5
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("round5", getObs(0), mkObs(0, 1, 0, 1, 0, 8'd5, 0));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort", getObs(0), mkObs(1, 0, 0, 0, 0, 8'd0, 0));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    // Start held high with ack high: count pulses over a whole number of operations
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b1; outAck = 1'b1;
    regCnt0 = 0; ldCnt0 = 0; regCnt2 = 0; ldCnt2 = 0;
    for (int i = 0; i < 52; i++) begin
      @(negedge clk);
      regCnt0 += int'(rgEn[0]); ldCnt0 += int'(ldEn[0]);
      regCnt2 += int'(rgEn[2]); ldCnt2 += int'(ldEn[2]);
    end
    chkInt("reg_pulses_default", regCnt0, 40);
    chkInt("load_pulses_default", ldCnt0, 4);
    chkInt("reg_pulses_n1", regCnt2, 13);
    chkInt("load_pulses_n1", ldCnt2, 13);

    // Random traffic against the timeline model
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 40) == 0);
      start = $urandom_range(0, 1) == 1;
      outAck = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end

    reset = 1'b0; start = 1'b0; outAck = 1'b1;
    repeat (40) @(negedge clk);
    monEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Sequencing controller for the iterative AES-128 encrypt datapath. Replaces the free-running round FSM: it accepts a start request, loads SecretKey/PlainText into the key and state registers, steps the round counter through rounds 1..NUM_ROUNDS, and drives the round-select mux (RoundA for rounds 1..N-1, RoundB for the final round). It then holds the result with a valid/ack handshake. All datapath registers are enabled only by this block; it contains no datapath itself.

## Interface
- NUM_ROUNDS, 10, total rounds; legal range 1..2^ROUND_W-1
- ROUND_W, 8, width of the round number bus (matches datapath iterate input)
- CYCLES_PER_ROUND, 1, clock cycles each round occupies (≥1; >1 for multicycle round logic)
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock is sufficient
- start  in  1  encryption request; accepted only when ready=1
- ready  out  1  high in IDLE only
- busy  out  1  high in LOAD, ROUND, DONE
- load_en  out  1  one-cycle pulse; key/state registers capture SecretKey/PlainText
- reg_en  out  1  key/state registers capture round outputs
- last_round  out  1  mux select; 1 = final-round (RoundB) path
- round  out  ROUND_W  current round number; 0 outside ROUND
- out_valid  out  1  CipherText stable and valid
- out_ack  in  1  consumer accepts CipherText

## Operation
- States: IDLE, LOAD, ROUND, DONE. Registered round counter (ROUND_W bits) and sub-cycle counter (clog2(CYCLES_PER_ROUND), minimum 1 bit).
- IDLE: ready=1; start=1 -> LOAD. Otherwise stay.
- LOAD: load_en=1 for exactly one cycle; round=0. Next state ROUND, round counter ← 1, sub counter ← 0.
- ROUND: round = counter value. last_round = (round == NUM_ROUNDS). reg_en=1 only in the sub-cycle where sub counter == CYCLES_PER_ROUND-1; sub counter increments otherwise.
- On the reg_en cycle: if round < NUM_ROUNDS, round ← round+1 and sub ← 0. If round == NUM_ROUNDS, go to DONE.
- DONE: out_valid=1; reg_en=0; registers hold. out_ack=1 -> IDLE on next edge. out_ack in other states is ignored.
- start is ignored in LOAD, ROUND and DONE. It is not queued.
- Outputs are decoded from registered state and counters only. There is no combinational path from start or out_ack to any output.
- NUM_ROUNDS=1: the single round has last_round=1. The counter never exceeds NUM_ROUNDS and never wraps.

## Timing
- Reset: state=IDLE, counters=0. Outputs on the cycle after reset: ready=1, busy=0, load_en=0, reg_en=0, last_round=0, round=0, out_valid=0.
- Reset asserted in any state (including mid-round or DONE with pending valid) aborts the operation. Next cycle is IDLE with the values above, and there are no further reg_en pulses.
- Reset and start in the same cycle: reset wins; start is dropped.
- start sampled high in IDLE at edge E -> LOAD during cycle E+1 -> round 1 begins at E+2.
- Latency from accepting edge to out_valid: 2 + NUM_ROUNDS×CYCLES_PER_ROUND cycles. Defaults give 12.
- reg_en pulse count per operation is exactly NUM_ROUNDS. load_en pulse count is exactly 1.
- out_ack high on the first DONE cycle -> out_valid lasts one cycle. ready=1 on the following cycle, and start can be accepted there (back-to-back throughput = latency + 1).
- out_valid holds indefinitely while out_ack=0.

## Test plan
- Defaults, start pulse at edge 0, out_ack tied 1:
  - load_en high in cycle 1 only.
  - round = 1..10 in cycles 2..11; reg_en high in cycles 2..11.
  - last_round high only in cycle 11.
  - out_valid high in cycle 12 only; ready=1 in cycle 13.
- CYCLES_PER_ROUND=3, NUM_ROUNDS=10:
  - each round value is held 3 cycles; reg_en fires on the 3rd cycle of each round.
  - out_valid appears 32 cycles after acceptance.
- Hold: out_ack=0 for 20 cycles after out_valid -> out_valid, round=0 and busy stay constant. A start pulsed during the hold is ignored. Then ack -> IDLE next cycle.
- Reset during round 5 -> next cycle IDLE, all outputs at reset values, no reg_en. A fresh start then runs the full 12-cycle sequence from round 1.
- NUM_ROUNDS=1 -> cycle 2 has round=1, last_round=1, reg_en=1; out_valid in cycle 3.
- Start held high continuously with out_ack=1 -> operations repeat with one ready cycle between them. Exactly 10 reg_en pulses and 1 load_en pulse per operation.
